// File: rtl/bcd_digit_entry.sv
// Two-digit BCD operand entry for the calculator keypad.
// Latches a tens/ones pair for conv_10 with a ready/ack handshake.
module bcd_digit_entry (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [0:3] key_code,
    input  logic       ack,
    output logic [0:3] disp_tens,
    output logic [0:3] disp_ones,
    output logic [0:3] op_tens,
    output logic [0:3] op_ones,
    output logic [1:0] count,
    output logic       ready,
    output logic       err
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t     state, state_nx;
    logic [0:3] tens_nx, ones_nx, opt_nx, opo_nx;
    logic [1:0] count_nx;
    logic       ready_nx, err_nx;
    logic       is_digit, is_clr, is_bs, is_ent;

    assign is_digit = key_valid && (key_code <= 4'd9);
    assign is_clr   = key_valid && (key_code == 4'hA);
    assign is_bs    = key_valid && (key_code == 4'hB);
    assign is_ent   = key_valid && (key_code == 4'hC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            disp_tens <= 4'd0;
            disp_ones <= 4'd0;
            op_tens   <= 4'd0;
            op_ones   <= 4'd0;
            count     <= 2'd0;
            ready     <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nx;
            disp_tens <= tens_nx;
            disp_ones <= ones_nx;
            op_tens   <= opt_nx;
            op_ones   <= opo_nx;
            count     <= count_nx;
            ready     <= ready_nx;
            err       <= err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            EMPTY: begin
                if (is_digit)    state_nx = ONE;
                else if (is_ent) state_nx = HOLD;
            end
            ONE: begin
                if (is_digit)              state_nx = TWO;
                else if (is_bs || is_clr)  state_nx = EMPTY;
                else if (is_ent)           state_nx = HOLD;
            end
            TWO: begin
                if (is_bs)       state_nx = ONE;
                else if (is_clr) state_nx = EMPTY;
                else if (is_ent) state_nx = HOLD;
            end
            HOLD: begin
                // ack has priority; a simultaneous key is dropped
                if (ack || is_clr) state_nx = EMPTY;
            end
        endcase
    end

    always_comb begin
        tens_nx = disp_tens;
        ones_nx = disp_ones;
        opt_nx  = op_tens;
        opo_nx  = op_ones;
        err_nx  = err;
        unique case (state)
            EMPTY: begin
                if (is_digit) begin
                    tens_nx = 4'd0;
                    ones_nx = key_code;
                end else if (is_ent) begin
                    opt_nx = disp_tens;
                    opo_nx = disp_ones;
                    err_nx = 1'b0;
                end else if (is_clr) begin
                    tens_nx = 4'd0;
                    ones_nx = 4'd0;
                    err_nx  = 1'b0;
                end
            end
            ONE: begin
                if (is_digit) begin
                    tens_nx = disp_ones;
                    ones_nx = key_code;
                end else if (is_bs) begin
                    tens_nx = 4'd0;
                    ones_nx = 4'd0;
                end else if (is_ent) begin
                    opt_nx = disp_tens;
                    opo_nx = disp_ones;
                    err_nx = 1'b0;
                end else if (is_clr) begin
                    tens_nx = 4'd0;
                    ones_nx = 4'd0;
                    err_nx  = 1'b0;
                end
            end
            TWO: begin
                if (is_digit) begin
                    err_nx = 1'b1;
                end else if (is_bs) begin
                    tens_nx = 4'd0;
                    ones_nx = disp_tens;
                end else if (is_ent) begin
                    opt_nx = disp_tens;
                    opo_nx = disp_ones;
                    err_nx = 1'b0;
                end else if (is_clr) begin
                    tens_nx = 4'd0;
                    ones_nx = 4'd0;
                    err_nx  = 1'b0;
                end
            end
            HOLD: begin
                if (ack) begin
                    tens_nx = 4'd0;
                    ones_nx = 4'd0;
                end else if (is_clr) begin
                    tens_nx = 4'd0;
                    ones_nx = 4'd0;
                    opt_nx  = 4'd0;
                    opo_nx  = 4'd0;
                    err_nx  = 1'b0;
                end
            end
        endcase
    end

    // count follows the entry; while holding it keeps the entered length
    always_comb begin
        count_nx = count;
        unique case (state_nx)
            EMPTY: count_nx = 2'd0;
            ONE:   count_nx = 2'd1;
            TWO:   count_nx = 2'd2;
            HOLD:  count_nx = count;
        endcase
        ready_nx = (state_nx == HOLD);
    end

endmodule

// File: tb/tb_bcd_digit_entry.sv
// Bench for bcd_digit_entry: directed test-plan cases with literal
// expectations, then random keys checked against a numeric model.
module tb_bcd_digit_entry;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [0:3] key_code = 4'd0;
    logic       ack = 1'b0;
    logic [0:3] disp_tens, disp_ones, op_tens, op_ones;
    logic [1:0] count;
    logic       ready, err;

    int checks = 0;
    int errors = 0;
    bit run    = 1'b0;

    int m_val, m_n, m_op, m_rdy, m_err;

    bcd_digit_entry dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_code  (key_code),
        .ack       (ack),
        .disp_tens (disp_tens),
        .disp_ones (disp_ones),
        .op_tens   (op_tens),
        .op_ones   (op_ones),
        .count     (count),
        .ready     (ready),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
        end
    endfunction

    // Model: entry is an integer 0..99 with a digit count
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_val = 0; m_n = 0; m_op = 0; m_rdy = 0; m_err = 0;
        end else if (m_rdy != 0) begin
            if (ack) begin
                m_rdy = 0; m_val = 0; m_n = 0;
            end else if (key_valid && key_code == 4'hA) begin
                m_rdy = 0; m_val = 0; m_n = 0; m_op = 0; m_err = 0;
            end
        end else if (key_valid) begin
            if (key_code <= 4'd9) begin
                if (m_n < 2) begin
                    m_val = (m_val * 10 + int'(key_code)) % 100;
                    m_n++;
                end else begin
                    m_err = 1;
                end
            end else if (key_code == 4'hA) begin
                m_val = 0; m_n = 0; m_err = 0;
            end else if (key_code == 4'hB) begin
                if (m_n > 0) begin
                    m_val = m_val / 10;
                    m_n--;
                end
            end else if (key_code == 4'hC) begin
                m_op = m_val; m_err = 0; m_rdy = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (run) begin
            chk("m_disp_tens", int'(disp_tens), m_val / 10);
            chk("m_disp_ones", int'(disp_ones), m_val % 10);
            chk("m_op_tens", int'(op_tens), m_op / 10);
            chk("m_op_ones", int'(op_ones), m_op % 10);
            chk("m_count", int'(count), m_n);
            chk("m_ready", int'(ready), m_rdy);
            chk("m_err", int'(err), m_err);
        end
    end

    // Drive one cycle's inputs from negedge+1; return at next negedge+1
    task automatic drive(input logic kv, input logic [3:0] kc, input logic a);
        key_valid = kv;
        key_code  = kc;
        ack       = a;
        @(negedge clk);
        #1;
        key_valid = 1'b0;
        ack       = 1'b0;
    endtask

    task automatic key(input logic [3:0] kc);
        drive(1'b1, kc, 1'b0);
    endtask

    function automatic int opnum();
        return int'(op_tens) * 10 + int'(op_ones);
    endfunction

    initial begin
        #1;
        chk("async_reset_disp", int'({disp_tens, disp_ones}), 0);
        chk("async_reset_op", int'({op_tens, op_ones}), 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        run = 1'b1;
        chk("reset_count", int'(count), 0);
        chk("reset_ready", int'(ready), 0);
        chk("reset_err", int'(err), 0);

        key(4'd5);
        chk("k5_tens", int'(disp_tens), 0);
        chk("k5_ones", int'(disp_ones), 5);
        chk("k5_count", int'(count), 1);
        key(4'd9);
        chk("k9_tens", int'(disp_tens), 5);
        chk("k9_ones", int'(disp_ones), 9);
        chk("k9_count", int'(count), 2);
        key(4'hC);
        chk("ent_ready", int'(ready), 1);
        chk("ent_op_tens", int'(op_tens), 4'b0101);
        chk("ent_op_ones", int'(op_ones), 4'b1001);
        chk("ent_conv", opnum(), 59);

        key(4'd8);
        chk("hold_digit_ready", int'(ready), 1);
        chk("hold_digit_op", opnum(), 59);
        chk("hold_digit_disp", int'(disp_ones), 9);

        drive(1'b1, 4'hA, 1'b1);
        chk("ackclr_ready", int'(ready), 0);
        chk("ackclr_op", opnum(), 59);
        chk("ackclr_count", int'(count), 0);

        key(4'd9); key(4'd9); key(4'd3);
        chk("third_err", int'(err), 1);
        chk("third_disp", int'({disp_tens, disp_ones}), 8'h99);
        key(4'hC);
        chk("ent99_op", opnum(), 99);
        chk("ent99_err", int'(err), 0);

        key(4'hA);
        chk("abort_op", opnum(), 0);
        chk("abort_ready", int'(ready), 0);

        key(4'd4); key(4'd7);
        key(4'hB);
        chk("bs1_disp", int'({disp_tens, disp_ones}), 8'h04);
        chk("bs1_count", int'(count), 1);
        key(4'hB);
        chk("bs2_disp", int'({disp_tens, disp_ones}), 8'h00);
        chk("bs2_count", int'(count), 0);
        key(4'hB);
        chk("bs3_count", int'(count), 0);

        key(4'd3); key(4'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_disp", int'({disp_tens, disp_ones}), 0);
        chk("midrst_count", int'(count), 0);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        key(4'd2); key(4'hC);
        chk("postrst_op", opnum(), 2);
        chk("postrst_ready", int'(ready), 1);

        for (int i = 0; i < 3000; i++) begin
            if (i % 600 == 599) begin
                rst = 1'b1;
                #2;
                rst = 1'b0;
            end
            drive(($urandom % 3) != 0,
                  4'($urandom_range(0, 15)),
                  ($urandom % 4) == 0);
        end

        run = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
